// File: rtl/exponent_seq_if.sv
// Handshake bundle for exponent_seq: index request in, one-hot result out.
// Both sides use valid/ready: a transfer happens on a rising edge where valid and ready are both high;
// valid is raised by the producer and stays high, with data stable, until that edge.
interface exponent_seq_if #(
    parameter int BIN_SIZE  = 8,
    parameter int BOUT_SIZE = 3
);
    logic                 inValid;
    logic                 inReady;
    logic [BOUT_SIZE-1:0] inNumber;
    logic                 outValid;
    logic                 outReady;
    logic [BIN_SIZE-1:0]  outVector;
    logic                 outError;

    modport slave (
        input  inValid, inNumber, outReady,
        output inReady, outValid, outVector, outError
    );

    modport master (
        output inValid, inNumber, outReady,
        input  inReady, outValid, outVector, outError
    );
endinterface

// File: rtl/exponent_seq.sv
// Expands a bit index n into the one-hot vector 1<<n by shifting a single 1 left once per clock.
// One request in flight; the result is held in DONE until the consumer takes it.
module exponent_seq #(
    parameter int BIN_SIZE  = 8,
    parameter int BOUT_SIZE = 3
) (
    input  logic              clk,
    input  logic              reset,
    exponent_seq_if.slave     bus,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [BIN_SIZE-1:0]  VEC_ONE   = BIN_SIZE'(1);
    localparam logic [BOUT_SIZE-1:0] COUNT_ONE = BOUT_SIZE'(1);

    state_t               state_q, state_d;
    logic [BOUT_SIZE-1:0] count_q, count_d;
    logic [BIN_SIZE-1:0]  out_vector_q, out_vector_d;
    logic                 out_error_q, out_error_d;
    logic                 in_range;

    // Range check is done at 32 bits so BIN_SIZE == 2**BOUT_SIZE never wraps.
    assign in_range = (32'(bus.inNumber) < 32'(BIN_SIZE));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            count_q      <= '0;
            out_vector_q <= '0;
            out_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            out_vector_q <= out_vector_d;
            out_error_q  <= out_error_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        out_vector_d = out_vector_q;
        out_error_d  = out_error_q;
        unique case (state_q)
            IDLE: begin
                if (bus.inValid) begin
                    if (!in_range) begin
                        out_vector_d = '0;
                        out_error_d  = 1'b1;
                        state_d      = DONE;
                    end else if (bus.inNumber == '0) begin
                        out_vector_d = VEC_ONE;
                        out_error_d  = 1'b0;
                        state_d      = DONE;
                    end else begin
                        out_vector_d = VEC_ONE;
                        out_error_d  = 1'b0;
                        count_d      = bus.inNumber;
                        state_d      = SHIFT;
                    end
                end
            end
            SHIFT: begin
                out_vector_d = out_vector_q << 1;
                count_d      = count_q - COUNT_ONE;
                if (count_q == COUNT_ONE) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.outReady) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // inReady is masked by reset so nothing is offered while the block is being cleared.
    always_comb begin
        bus.inReady   = (state_q == IDLE) && !reset;
        bus.outValid  = (state_q == DONE);
        bus.outVector = out_vector_q;
        bus.outError  = out_error_q;
        dbg_state     = state_q;
    end

endmodule
